// File: rtl/regfile_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// regfile_ctrl_pkg
// Shared definitions for the register-file access controller:
//   - default geometry (address width, data width, registers swept by CLEAR)
//   - host command opcodes
//   - controller state encoding and write-strobe phase encoding
// Optional feature macro used by the importing RTL: REGFILE_ZERO_PROTECT_EN.
// -----------------------------------------------------------------------------
package regfile_ctrl_pkg;

    localparam int DEFAULT_ADDR_W   = 5;
    localparam int DEFAULT_DATA_W   = 32;
    localparam int DEFAULT_NUM_REGS = 32;

    localparam logic [1:0] OP_NOP   = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_READ  = 2'b10;
    localparam logic [1:0] OP_CLEAR = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_WR_SETUP   = 3'd1,
        ST_WR_STROBE  = 3'd2,
        ST_WR_HOLD    = 3'd3,
        ST_RD_ADDR    = 3'd4,
        ST_RD_CAPTURE = 3'd5,
        ST_RSP        = 3'd6
    } ctrl_state_e;

    typedef enum logic [1:0] {
        PH_IDLE   = 2'd0,
        PH_SETUP  = 2'd1,
        PH_STROBE = 2'd2,
        PH_HOLD   = 2'd3
    } strobe_phase_e;

endpackage

// File: rtl/regfile_write_strobe.sv
// -----------------------------------------------------------------------------
// regfile_write_strobe
// Drives one register-file write as a three-cycle SETUP / STROBE / HOLD
// sequence. Address and data are captured on start and held until the next
// start, so they never move while RegWrite is high.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   start             load addr/data and begin SETUP on the next cycle
//   addr, data        register index and value to write
//   WriteRg/WriteData registered write address/data to the register file
//   RegWrite          registered one-cycle write strobe (STROBE phase only)
//   done              high during HOLD, the last cycle of the sequence
// -----------------------------------------------------------------------------
module regfile_write_strobe
    import regfile_ctrl_pkg::*;
#(
    parameter int ADDR_W = DEFAULT_ADDR_W,
    parameter int DATA_W = DEFAULT_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] data,
    output logic [ADDR_W-1:0] WriteRg,
    output logic [DATA_W-1:0] WriteData,
    output logic              RegWrite,
    output logic              done
);

    strobe_phase_e     phase_q, phase_d;
    logic [ADDR_W-1:0] write_rg_q, write_rg_d;
    logic [DATA_W-1:0] write_data_q, write_data_d;
    logic              reg_write_q, reg_write_d;

    // Phase sequencing and capture of the address/data for this write.
    always_comb begin
        phase_d      = phase_q;
        write_rg_d   = write_rg_q;
        write_data_d = write_data_q;
        if (start) begin
            phase_d      = PH_SETUP;
            write_rg_d   = addr;
            write_data_d = data;
        end else begin
            case (phase_q)
                PH_SETUP:  phase_d = PH_STROBE;
                PH_STROBE: phase_d = PH_HOLD;
                PH_HOLD:   phase_d = PH_IDLE;
                default:   phase_d = PH_IDLE;
            endcase
        end
        // Strobe is registered so it is high exactly in the STROBE cycle.
        reg_write_d = (phase_d == PH_STROBE);
    end

    // Phase and output registers; reset drops RegWrite immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q      <= PH_IDLE;
            write_rg_q   <= {ADDR_W{1'b0}};
            write_data_q <= {DATA_W{1'b0}};
            reg_write_q  <= 1'b0;
        end else begin
            phase_q      <= phase_d;
            write_rg_q   <= write_rg_d;
            write_data_q <= write_data_d;
            reg_write_q  <= reg_write_d;
        end
    end

    assign WriteRg   = write_rg_q;
    assign WriteData = write_data_q;
    assign RegWrite  = reg_write_q;
    assign done      = (phase_q == PH_HOLD);

endmodule

// File: rtl/regfile_access_ctrl.sv
// -----------------------------------------------------------------------------
// regfile_access_ctrl
// Initiator for a register file with two combinational read ports and one
// strobed write port. Host commands (NOP/WRITE/READ/CLEAR) arrive over a
// valid/ready channel; READ results return over a valid/ready response.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   cmd_valid/cmd_ready        command handshake (ready only when idle)
//   cmd_op, cmd_addr_a/b       opcode, write/port-1 address, port-2 address
//   cmd_wdata                  write data
//   rsp_valid/rsp_ready        read response handshake
//   rsp_data_a/b               captured RD1/RD2
//   busy                       controller not idle
//   RR1, RR2, RD1, RD2         register-file read ports
//   WriteRg, WriteData, RegWrite register-file write port
// Optional feature macro: REGFILE_ZERO_PROTECT_EN (register 0 is read-only
// zero: writes to it are dropped, reads of it return 0, CLEAR skips it).
// -----------------------------------------------------------------------------
module regfile_access_ctrl
    import regfile_ctrl_pkg::*;
#(
    parameter int ADDR_W   = DEFAULT_ADDR_W,
    parameter int DATA_W   = DEFAULT_DATA_W,
    parameter int NUM_REGS = DEFAULT_NUM_REGS
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_addr_a,
    input  logic [ADDR_W-1:0] cmd_addr_b,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data_a,
    output logic [DATA_W-1:0] rsp_data_b,
    output logic              busy,
    output logic [ADDR_W-1:0] RR1,
    output logic [ADDR_W-1:0] RR2,
    output logic [ADDR_W-1:0] WriteRg,
    output logic [DATA_W-1:0] WriteData,
    output logic              RegWrite,
    input  logic [DATA_W-1:0] RD1,
    input  logic [DATA_W-1:0] RD2
);

    localparam logic [ADDR_W-1:0] CLR_LAST = ADDR_W'(NUM_REGS - 1);
    localparam logic [ADDR_W-1:0] CNT_ONE  = ADDR_W'(1'b1);
`ifdef REGFILE_ZERO_PROTECT_EN
    localparam logic [ADDR_W-1:0] CLR_FIRST = ADDR_W'(1'b1);
`else
    localparam logic [ADDR_W-1:0] CLR_FIRST = {ADDR_W{1'b0}};
`endif

    ctrl_state_e       state_q, state_d;
    logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
    logic              clearing_q, clearing_d;
    logic [ADDR_W-1:0] rr1_q, rr1_d, rr2_q, rr2_d;
    logic [DATA_W-1:0] rsp_data_a_q, rsp_data_a_d, rsp_data_b_q, rsp_data_b_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              busy_q, busy_d;
    logic              cmd_ready_q, cmd_ready_d;

    logic              accept_s;
    logic              drop_wr_s;
    logic              wr_start_s;
    logic [ADDR_W-1:0] wr_addr_s;
    logic [DATA_W-1:0] wr_data_s;
    logic              wr_done_s;

    assign accept_s = cmd_valid && cmd_ready_q;

`ifdef REGFILE_ZERO_PROTECT_EN
    assign drop_wr_s = (cmd_addr_a == {ADDR_W{1'b0}});
`else
    assign drop_wr_s = 1'b0;
`endif

    // State, clear-counter and response registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            clr_cnt_q    <= {ADDR_W{1'b0}};
            clearing_q   <= 1'b0;
            rr1_q        <= {ADDR_W{1'b0}};
            rr2_q        <= {ADDR_W{1'b0}};
            rsp_data_a_q <= {DATA_W{1'b0}};
            rsp_data_b_q <= {DATA_W{1'b0}};
            rsp_valid_q  <= 1'b0;
            busy_q       <= 1'b0;
            cmd_ready_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            clr_cnt_q    <= clr_cnt_d;
            clearing_q   <= clearing_d;
            rr1_q        <= rr1_d;
            rr2_q        <= rr2_d;
            rsp_data_a_q <= rsp_data_a_d;
            rsp_data_b_q <= rsp_data_b_d;
            rsp_valid_q  <= rsp_valid_d;
            busy_q       <= busy_d;
            cmd_ready_q  <= cmd_ready_d;
        end
    end

    // Next-state logic, including the CLEAR sweep counter.
    always_comb begin
        state_d    = state_q;
        clr_cnt_d  = clr_cnt_q;
        clearing_d = clearing_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    case (cmd_op)
                        OP_WRITE: begin
                            if (drop_wr_s) begin
                                state_d = ST_IDLE;
                            end else begin
                                state_d    = ST_WR_SETUP;
                                clearing_d = 1'b0;
                            end
                        end
                        OP_READ: state_d = ST_RD_ADDR;
                        OP_CLEAR: begin
                            state_d    = ST_WR_SETUP;
                            clearing_d = 1'b1;
                            clr_cnt_d  = CLR_FIRST;
                        end
                        default: state_d = ST_IDLE;
                    endcase
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WR_SETUP:  state_d = ST_WR_STROBE;
            ST_WR_STROBE: state_d = ST_WR_HOLD;
            ST_WR_HOLD: begin
                if (!wr_done_s) begin
                    state_d = ST_WR_HOLD;
                end else if (clearing_q && (clr_cnt_q != CLR_LAST)) begin
                    state_d   = ST_WR_SETUP;
                    clr_cnt_d = clr_cnt_q + CNT_ONE;
                end else begin
                    // Counter returns to 0 so the next CLEAR starts clean.
                    state_d    = ST_IDLE;
                    clr_cnt_d  = {ADDR_W{1'b0}};
                    clearing_d = 1'b0;
                end
            end
            ST_RD_ADDR:    state_d = ST_RD_CAPTURE;
            ST_RD_CAPTURE: state_d = ST_RSP;
            ST_RSP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_RSP;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output logic: write-sequence launch, read address/capture, status flags.
    always_comb begin
        // Every entry into WR_SETUP launches one strobe sequence.
        wr_start_s = (state_d == ST_WR_SETUP);
        if (clearing_d) begin
            wr_addr_s = clr_cnt_d;
            wr_data_s = {DATA_W{1'b0}};
        end else begin
            wr_addr_s = cmd_addr_a;
            wr_data_s = cmd_wdata;
        end

        if ((state_q == ST_IDLE) && accept_s && (cmd_op == OP_READ)) begin
            rr1_d = cmd_addr_a;
            rr2_d = cmd_addr_b;
        end else begin
            rr1_d = rr1_q;
            rr2_d = rr2_q;
        end

        if (state_q == ST_RD_CAPTURE) begin
`ifdef REGFILE_ZERO_PROTECT_EN
            rsp_data_a_d = (rr1_q == {ADDR_W{1'b0}}) ? {DATA_W{1'b0}} : RD1;
            rsp_data_b_d = (rr2_q == {ADDR_W{1'b0}}) ? {DATA_W{1'b0}} : RD2;
`else
            rsp_data_a_d = RD1;
            rsp_data_b_d = RD2;
`endif
        end else begin
            rsp_data_a_d = rsp_data_a_q;
            rsp_data_b_d = rsp_data_b_q;
        end

        rsp_valid_d = (state_d == ST_RSP);
        busy_d      = (state_d != ST_IDLE);
        cmd_ready_d = (state_d == ST_IDLE);
    end

    regfile_write_strobe #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_write_strobe (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (wr_start_s),
        .addr      (wr_addr_s),
        .data      (wr_data_s),
        .WriteRg   (WriteRg),
        .WriteData (WriteData),
        .RegWrite  (RegWrite),
        .done      (wr_done_s)
    );

    assign cmd_ready  = cmd_ready_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_data_a = rsp_data_a_q;
    assign rsp_data_b = rsp_data_b_q;
    assign busy       = busy_q;
    assign RR1        = rr1_q;
    assign RR2        = rr2_q;

endmodule

// File: tb/tb_regfile_access_ctrl.sv
// -----------------------------------------------------------------------------
// tb_regfile_access_ctrl
// Bench for regfile_access_ctrl with a behavioural register file. Expected
// strobes and read responses are queued when commands are issued and checked
// by a negedge monitor when the DUT produces them. Honours
// REGFILE_ZERO_PROTECT_EN when compiled with it.
// -----------------------------------------------------------------------------
module tb_regfile_access_ctrl;
    import regfile_ctrl_pkg::*;

`ifdef REGFILE_ZERO_PROTECT_EN
    localparam bit PROT = 1'b1;
    localparam int FIRST = 1;
`else
    localparam bit PROT = 1'b0;
    localparam int FIRST = 0;
`endif
    localparam int NCLR = 32 - FIRST;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid, cmd_ready;
    logic [1:0]  cmd_op;
    logic [4:0]  cmd_addr_a, cmd_addr_b;
    logic [31:0] cmd_wdata;
    logic        rsp_valid, rsp_ready;
    logic [31:0] rsp_data_a, rsp_data_b;
    logic        busy;
    logic [4:0]  RR1, RR2, WriteRg;
    logic [31:0] WriteData, RD1, RD2;
    logic        RegWrite;

    always #5 clk = ~clk;

    regfile_access_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_addr_a(cmd_addr_a), .cmd_addr_b(cmd_addr_b), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data_a(rsp_data_a), .rsp_data_b(rsp_data_b), .busy(busy),
        .RR1(RR1), .RR2(RR2), .WriteRg(WriteRg), .WriteData(WriteData),
        .RegWrite(RegWrite), .RD1(RD1), .RD2(RD2)
    );

    // Behavioural register file: initial contents 0x1000_0000 + index.
    logic [31:0] mem [32];
    logic        mem_loaded = 1'b0;
    logic        rd1_force = 1'b0;
    always @(posedge clk) begin
        if (!mem_loaded) begin
            for (int i = 0; i < 32; i++) mem[i] <= 32'h1000_0000 + 32'(i);
            mem_loaded <= 1'b1;
        end else if (RegWrite) begin
            mem[WriteRg] <= WriteData;
        end
    end
    assign RD1 = rd1_force ? 32'hFFFF_FFFF : mem[RR1];
    assign RD2 = mem[RR2];

    typedef struct { logic [4:0] addr; logic [31:0] data; } wr_exp_t;
    typedef struct { logic [31:0] a; logic [31:0] b; } rsp_exp_t;
    wr_exp_t wr_q[$];
    rsp_exp_t rsp_q[$];

    int checks = 0;
    int errors = 0;
    int strobe_count = 0;
    logic prev_rw = 1'b0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    // Monitor: match every strobe and every accepted response to the queues.
    always @(negedge clk) begin
        wr_exp_t  we;
        rsp_exp_t re;
        if (!rst_n) begin
            prev_rw <= 1'b0;
        end else begin
            if (RegWrite) begin
                strobe_count <= strobe_count + 1;
                chk("regwrite_back_to_back", 32'(prev_rw), 32'd0);
                if (wr_q.size() == 0) begin
                    chk("unexpected_strobe_addr", 32'(WriteRg), 32'hFFFF_FFFF);
                end else begin
                    we = wr_q.pop_front();
                    chk("strobe_addr", 32'(WriteRg), 32'(we.addr));
                    chk("strobe_data", WriteData, we.data);
                end
            end
            prev_rw <= RegWrite;
            if (rsp_valid && rsp_ready) begin
                if (rsp_q.size() == 0) begin
                    chk("unexpected_rsp", rsp_data_a, 32'hFFFF_FFFF);
                end else begin
                    re = rsp_q.pop_front();
                    chk("rsp_data_a", rsp_data_a, re.a);
                    chk("rsp_data_b", rsp_data_b, re.b);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a command and hold it until the acceptance edge; returns in cycle 1.
    task automatic issue(input logic [1:0] op, input logic [4:0] a, input logic [4:0] b,
                         input logic [31:0] d);
        int n = 0;
        cmd_op = op; cmd_addr_a = a; cmd_addr_b = b; cmd_wdata = d; cmd_valid = 1'b1;
        while (!cmd_ready && n < 500) begin
            tick();
            n++;
        end
        if (n >= 500) chk("cmd_ready_timeout", 32'(cmd_ready), 32'd1);
        tick();
        cmd_valid = 1'b0;
        cmd_op = 2'b00; cmd_addr_a = 5'd31; cmd_addr_b = 5'd31; cmd_wdata = 32'h0BAD_0BAD;
    endtask

    task automatic push_wr(input logic [4:0] a, input logic [31:0] d);
        wr_exp_t e;
        e.addr = a; e.data = d;
        wr_q.push_back(e);
    endtask

    task automatic push_rsp(input logic [31:0] a, input logic [31:0] b);
        rsp_exp_t e;
        e.a = a; e.b = b;
        rsp_q.push_back(e);
    endtask

    // Wait (bounded) until all expected strobes/responses were seen and idle.
    task automatic drain();
        int n = 0;
        while ((rsp_q.size() != 0 || wr_q.size() != 0 || !cmd_ready) && n < 400) begin
            tick();
            n++;
        end
        chk("drain_timeout", 32'(n < 400), 32'd1);
    endtask

    typedef struct {
        logic [1:0] op; logic [4:0] a; logic [4:0] b; logic [31:0] wdata;
        logic [31:0] exp_a; logic [31:0] exp_b;
    } vec_t;
    vec_t vecs[10];

    initial begin
        int s0;
        int n;
        vecs[0] = '{OP_WRITE, 5'd31, 5'd0,  32'h0F0F_0F0F, 32'h0, 32'h0};
        vecs[1] = '{OP_NOP,   5'd3,  5'd4,  32'h1111_1111, 32'h0, 32'h0};
        vecs[2] = '{OP_READ,  5'd31, 5'd5,  32'h0,         32'h0F0F_0F0F, 32'hAAAA_AAAA};
        vecs[3] = '{OP_WRITE, 5'd0,  5'd0,  32'h1357_9BDF, 32'h0, 32'h0};
        if (PROT) vecs[4] = '{OP_READ, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0};
        else      vecs[4] = '{OP_READ, 5'd0, 5'd0, 32'h0, 32'h1357_9BDF, 32'h1357_9BDF};
        vecs[5] = '{OP_WRITE, 5'd5,  5'd0,  32'h5555_5555, 32'h0, 32'h0};
        vecs[6] = '{OP_READ,  5'd5,  5'd22, 32'h0,         32'h5555_5555, 32'hDEAD_BEEF};
        vecs[7] = '{OP_READ,  5'd3,  5'd17, 32'h0,         32'h1000_0003, 32'h1000_0011};
        vecs[8] = '{OP_WRITE, 5'd17, 5'd0,  32'hFFFF_FFFF, 32'h0, 32'h0};
        vecs[9] = '{OP_READ,  5'd17, 5'd31, 32'h0,         32'hFFFF_FFFF, 32'h0F0F_0F0F};

        rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_addr_a = 5'd0;
        cmd_addr_b = 5'd0; cmd_wdata = 32'h0; rsp_ready = 1'b1;
        #1;
        chk("reset_cmd_ready", 32'(cmd_ready), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_regwrite", 32'(RegWrite), 32'd0);
        chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        tick(); tick();
        rst_n = 1'b1;
        tick();
        chk("release_cmd_ready", 32'(cmd_ready), 32'd1);

        // WRITE 5 = AAAAAAAA with cycle-accurate timing.
        push_wr(5'd5, 32'hAAAA_AAAA);
        issue(OP_WRITE, 5'd5, 5'd0, 32'hAAAA_AAAA);
        chk("wr_c1_regwrite", 32'(RegWrite), 32'd0);
        chk("wr_c1_writerg", 32'(WriteRg), 32'd5);
        chk("wr_c1_busy", 32'(busy), 32'd1);
        chk("wr_c1_cmd_ready", 32'(cmd_ready), 32'd0);
        tick();
        chk("wr_c2_regwrite", 32'(RegWrite), 32'd1);
        chk("wr_c2_writedata", WriteData, 32'hAAAA_AAAA);
        tick();
        chk("wr_c3_regwrite", 32'(RegWrite), 32'd0);
        chk("wr_c3_writerg", 32'(WriteRg), 32'd5);
        chk("wr_c3_cmd_ready", 32'(cmd_ready), 32'd0);
        tick();
        chk("wr_c4_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("wr_c4_busy", 32'(busy), 32'd0);

        // READ 5/10 timing.
        push_rsp(32'hAAAA_AAAA, 32'h1000_000A);
        issue(OP_READ, 5'd5, 5'd10, 32'h0);
        chk("rd_c1_rr1", 32'(RR1), 32'd5);
        chk("rd_c1_rr2", 32'(RR2), 32'd10);
        chk("rd_c1_rsp_valid", 32'(rsp_valid), 32'd0);
        tick();
        chk("rd_c2_rsp_valid", 32'(rsp_valid), 32'd0);
        tick();
        chk("rd_c3_rsp_valid", 32'(rsp_valid), 32'd1);
        drain();

        // WRITE 22, READ 22/5 with response back-pressure.
        push_wr(5'd22, 32'hDEAD_BEEF);
        issue(OP_WRITE, 5'd22, 5'd0, 32'hDEAD_BEEF);
        rsp_ready = 1'b0;
        push_rsp(32'hDEAD_BEEF, 32'hAAAA_AAAA);
        issue(OP_READ, 5'd22, 5'd5, 32'h0);
        tick(); tick();
        for (int i = 0; i < 4; i++) begin
            chk("hold_rsp_valid", 32'(rsp_valid), 32'd1);
            chk("hold_cmd_ready", 32'(cmd_ready), 32'd0);
            chk("hold_data_a", rsp_data_a, 32'hDEAD_BEEF);
            chk("hold_data_b", rsp_data_b, 32'hAAAA_AAAA);
            tick();
        end
        rsp_ready = 1'b1;
        tick();
        chk("after_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("after_rsp_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("after_rsp_data_a", rsp_data_a, 32'hDEAD_BEEF);
        drain();

`ifdef REGFILE_ZERO_PROTECT_EN
        // Writes to register 0 are dropped; lane with address 0 reads as 0.
        s0 = strobe_count;
        issue(OP_WRITE, 5'd0, 5'd0, 32'h1234_5678);
        chk("zp_wr0_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("zp_wr0_busy", 32'(busy), 32'd0);
        tick(); tick(); tick();
        chk("zp_wr0_no_strobe", 32'(strobe_count - s0), 32'd0);
        rd1_force = 1'b1;
        push_rsp(32'h0, 32'hDEAD_BEEF);
        issue(OP_READ, 5'd0, 5'd22, 32'h0);
        drain();
        rd1_force = 1'b0;
`endif

        // Table-driven command sequence.
        for (int i = 0; i < 10; i++) begin
            if (vecs[i].op == OP_WRITE && !(PROT && vecs[i].a == 5'd0))
                push_wr(vecs[i].a, vecs[i].wdata);
            if (vecs[i].op == OP_READ)
                push_rsp(vecs[i].exp_a, vecs[i].exp_b);
            s0 = strobe_count;
            issue(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].wdata);
            if (vecs[i].op == OP_NOP) begin
                chk("nop_cmd_ready", 32'(cmd_ready), 32'd1);
                chk("nop_busy", 32'(busy), 32'd0);
            end
        end
        drain();

        // Full CLEAR: one strobe per register over 3 cycles each.
        s0 = strobe_count;
        for (int i = FIRST; i < 32; i++) push_wr(5'(i), 32'h0);
        issue(OP_CLEAR, 5'd0, 5'd0, 32'h0);
        n = 0;
        while (!cmd_ready && n < 300) begin
            tick();
            n++;
        end
        chk("clear_cycles", 32'(n), 32'(3 * NCLR));
        chk("clear_strobes", 32'(strobe_count - s0), 32'(NCLR));
        chk("clear_queue_empty", 32'(wr_q.size()), 32'd0);
        push_rsp(32'h0, 32'h0);
        issue(OP_READ, 5'd22, 5'd5, 32'h0);
        drain();

        // Reset during the idx 7 strobe of a CLEAR.
        for (int i = FIRST; i < 32; i++) push_wr(5'(i), 32'h0);
        issue(OP_CLEAR, 5'd0, 5'd0, 32'h0);
        n = 0;
        while (!(RegWrite && WriteRg == 5'd7) && n < 400) begin
            tick();
            n++;
        end
        chk("midclear_reach_idx7", 32'(n < 400), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("midclear_regwrite", 32'(RegWrite), 32'd0);
        chk("midclear_busy", 32'(busy), 32'd0);
        chk("midclear_writerg", 32'(WriteRg), 32'd0);
        wr_q.delete();
        rsp_q.delete();
        tick();
        rst_n = 1'b1;
        s0 = strobe_count;
        tick();
        chk("midclear_cmd_ready", 32'(cmd_ready), 32'd1);
        for (int i = 0; i < 10; i++) tick();
        chk("midclear_no_strobes", 32'(strobe_count - s0), 32'd0);
        chk("midclear_idle_busy", 32'(busy), 32'd0);
        push_rsp(32'h0, 32'h0);
        issue(OP_READ, 5'd7, 5'd6, 32'h0);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Watchdog against a hung run.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
